// File: rtl/cu.sv
// cu: execute stage of the 8-bit ALU; decodes {opcode,A,B} and registers result and flags one cycle later.
module cu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [18:0] instruction,
  output logic [7:0]  result,
  output logic        out_valid,
  output logic        carry,
  output logic        zero
);
  logic [2:0]  op;
  logic [7:0]  a, b;
  logic [8:0]  sum, diff;
  logic [15:0] prod;
  logic [7:0]  result_d, result_q;
  logic        carry_d, carry_q, zero_d, zero_q, valid_d, valid_q;
  assign op   = instruction[18:16];
  assign a    = instruction[15:8];
  assign b    = instruction[7:0];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = 16'(a) * 16'(b);
  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    valid_d  = in_valid;
    if (in_valid && op != 3'b000) begin
      unique case (op)
        3'b001:  begin result_d = sum[7:0];   carry_d = sum[8];          end
        3'b010:  begin result_d = diff[7:0];  carry_d = diff[8];         end
        3'b011:  begin result_d = prod[7:0];  carry_d = |prod[15:8];     end
        3'b100:  begin result_d = a & b;      carry_d = 1'b0;            end
        3'b101:  begin result_d = a | b;      carry_d = 1'b0;            end
        3'b110:  begin result_d = a ^ b;      carry_d = 1'b0;            end
        default: begin result_d = ~a;         carry_d = 1'b0;            end
      endcase
      zero_d = (result_d == 8'h00);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 8'h00;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_cu.sv
// tb_cu: randomized and directed checks of cu against an arithmetic reference model.
module tb_cu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [18:0] instruction = '0;
  logic [7:0]  result;
  logic        out_valid, carry, zero;
  int checks = 0;
  int errors = 0;
  logic [7:0] m_r = 8'h00;
  logic       m_c = 1'b0, m_z = 1'b0, m_v = 1'b0;

  cu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instruction(instruction),
    .result(result), .out_valid(out_valid), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic model(input bit v, input int op, input int a, input int b);
    int t;
    m_v = v;
    if (!v || op == 0) return;
    m_c = 1'b0;
    case (op)
      1: begin t = a + b;       m_c = (t > 255);     end
      2: begin t = a - b + 256; m_c = (a < b);       end
      3: begin t = a * b;       m_c = (t >= 256);    end
      4: t = a & b;
      5: t = a | b;
      6: t = a ^ b;
      default: t = 255 - a;
    endcase
    m_r = 8'(t % 256);
    m_z = (m_r == 8'h00);
  endtask

  task automatic model_clear();
    m_r = 8'h00; m_c = 1'b0; m_z = 1'b0; m_v = 1'b0;
  endtask

  task automatic step(input bit v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    instruction = {op, a, b};
    @(posedge clk);
    #1;
    model(v, int'(op), int'(a), int'(b));
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({result, carry, zero, out_valid} !== 11'h0) begin
      errors++;
      $display("FAIL reset_immediate got r=%h c=%b z=%b v=%b want 00 0 0 0", result, carry, zero, out_valid);
    end
    in_valid = 1'b1;
    instruction = {3'b001, 8'h10, 8'h20};
    @(posedge clk);
    #1;
    checks++;
    if ({result, carry, zero, out_valid} !== 11'h0) begin
      errors++;
      $display("FAIL reset_held got r=%h c=%b z=%b v=%b want 00 0 0 0", result, carry, zero, out_valid);
    end
    #2 rst_n = 1'b1;
    in_valid = 1'b0;
    model_clear();
  endtask

  task automatic test_sweep();
    logic [7:0] exp_r [7] = '{8'h37, 8'h0F, 8'hBC, 8'h00, 8'h37, 8'h37, 8'hDC};
    logic       exp_c [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       exp_z [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 3'(i + 1), 8'h23, 8'h14);
      checks++;
      if (result !== exp_r[i] || carry !== exp_c[i] || zero !== exp_z[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL sweep op=%0d got r=%h c=%b z=%b v=%b want %h %b %b 1",
                 i + 1, result, carry, zero, out_valid, exp_r[i], exp_c[i], exp_z[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [2:0] ops [3] = '{3'b001, 3'b010, 3'b011};
    logic [7:0] as  [3] = '{8'hFF, 8'h00, 8'hFF};
    logic [7:0] bs  [3] = '{8'h01, 8'h01, 8'hFF};
    logic [7:0] er  [3] = '{8'h00, 8'hFF, 8'h01};
    logic       ez  [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ops[i], as[i], bs[i]);
      checks++;
      if (result !== er[i] || carry !== 1'b1 || zero !== ez[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL boundary %0d got r=%h c=%b z=%b v=%b want %h 1 %b 1",
                 i, result, carry, zero, out_valid, er[i], ez[i]);
      end
    end
  endtask

  task automatic test_hold();
    step(1'b1, 3'b011, 8'h23, 8'h14);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'(i + 1), 8'h55, 8'hAA);
      checks++;
      if (result !== 8'hBC || carry !== 1'b1 || zero !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_idle %0d got r=%h c=%b z=%b v=%b want bc 1 0 0", i, result, carry, zero, out_valid);
      end
    end
    step(1'b1, 3'b100, 8'h0F, 8'hF0);
    step(1'b1, 3'b000, 8'h12, 8'h34);
    checks++;
    if (result !== 8'h00 || carry !== 1'b0 || zero !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_nop got r=%h c=%b z=%b v=%b want 00 0 1 1", result, carry, zero, out_valid);
    end
    step(1'b0, 3'b001, 8'h01, 8'h01);
    checks++;
    if (out_valid !== 1'b0 || result !== 8'h00) begin
      errors++;
      $display("FAIL hold_after_nop got r=%h v=%b want 00 0", result, out_valid);
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [7:0] a, b;
    bit v;
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      step(v, op, a, b);
      checks++;
      if (result !== m_r || carry !== m_c || zero !== m_z || out_valid !== m_v) begin
        errors++;
        $display("FAIL random %0d op=%0d a=%h b=%h v=%b got r=%h c=%b z=%b ov=%b want %h %b %b %b",
                 i, op, a, b, v, result, carry, zero, out_valid, m_r, m_c, m_z, m_v);
      end
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b1, 3'b001, 8'hF0, 8'h20);
    step(1'b1, 3'b011, 8'h40, 8'h08);
    #2;
    rst_n = 1'b0;
    instruction = {3'b111, 8'h00, 8'h00};
    #1;
    checks++;
    if ({result, carry, zero, out_valid} !== 11'h0) begin
      errors++;
      $display("FAIL midreset_clear got r=%h c=%b z=%b v=%b want 00 0 0 0", result, carry, zero, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({result, carry, zero, out_valid} !== 11'h0) begin
      errors++;
      $display("FAIL midreset_held got r=%h c=%b z=%b v=%b want 00 0 0 0", result, carry, zero, out_valid);
    end
    #2 rst_n = 1'b1;
    model_clear();
    step(1'b1, 3'b010, 8'h05, 8'h09);
    checks++;
    if (result !== 8'hFC || carry !== 1'b1 || zero !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_first got r=%h c=%b z=%b v=%b want fc 1 0 1", result, carry, zero, out_valid);
    end
    step(1'b1, 3'b110, 8'h5A, 8'h5A);
    checks++;
    if (result !== m_r || carry !== m_c || zero !== m_z || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_second got r=%h c=%b z=%b want %h %b %b", result, carry, zero, m_r, m_c, m_z);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_boundaries();
    test_hold();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
